// File: rtl/ctrl_pipe_unit_if.sv
// ID-stage instruction/flush inputs and per-stage control outputs of ctrl_pipe_unit.
// master drives the ID stage and observes the stages; slave is the control pipeline.
interface ctrl_pipe_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 8
);
  logic                  Valid_i;
  logic [5:0]            Op_i;
  logic [REG_ADDR_W-1:0] Rs_i;
  logic [REG_ADDR_W-1:0] Rt_i;
  logic [REG_ADDR_W-1:0] Rd_i;
  logic                  Flush_i;
  logic                  Stall_o;
  logic                  Jump_o;
  logic                  ExRegDst_o;
  logic [1:0]            ExALUOp_o;
  logic                  ExALUSrc_o;
  logic [REG_ADDR_W-1:0] ExDst_o;
  logic                  MemRead_o;
  logic                  MemWrite_o;
  logic                  MemBranch_o;
  logic                  WbRegWrite_o;
  logic                  WbMemtoReg_o;
  logic [REG_ADDR_W-1:0] WbDst_o;
  logic                  Illegal_o;
  logic [CNT_W-1:0]      IllegalCnt_o;

  modport master (
    output Valid_i, Op_i, Rs_i, Rt_i, Rd_i, Flush_i,
    input  Stall_o, Jump_o, ExRegDst_o, ExALUOp_o, ExALUSrc_o, ExDst_o,
           MemRead_o, MemWrite_o, MemBranch_o, WbRegWrite_o, WbMemtoReg_o,
           WbDst_o, Illegal_o, IllegalCnt_o
  );

  modport slave (
    input  Valid_i, Op_i, Rs_i, Rt_i, Rd_i, Flush_i,
    output Stall_o, Jump_o, ExRegDst_o, ExALUOp_o, ExALUSrc_o, ExDst_o,
           MemRead_o, MemWrite_o, MemBranch_o, WbRegWrite_o, WbMemtoReg_o,
           WbDst_o, Illegal_o, IllegalCnt_o
  );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Pipelined main decoder: EX fields 1 cycle after ID, MEM 2, WB 3; illegal opcodes counted.
// Load-use hazard gives a 1-cycle combinational stall (ID/EX bubble); flush wins; later stages never stall.
module ctrl_pipe_unit #(
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_W          = 8,
  parameter bit HAZARD_EN      = 1'b1,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  ctrl_pipe_unit_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  ctrl_t                 dec;
  logic                  legal;
  logic                  uses_rt;
  logic                  hazard;
  logic [REG_ADDR_W-1:0] dec_dst;
  ctrl_t                 idex_ctrl_d, idex_ctrl_q;
  logic [REG_ADDR_W-1:0] idex_dst_d, idex_dst_q;
  mem_ctrl_t             exmem_ctrl_q;
  logic [REG_ADDR_W-1:0] exmem_dst_q;
  wb_ctrl_t              memwb_ctrl_q;
  logic [REG_ADDR_W-1:0] memwb_dst_q;
  logic                  ill_d, ill_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;

  always_comb begin
    dec     = '0;
    dec_dst = '0;
    legal   = 1'b1;
    uses_rt = 1'b0;
    case (bus.Op_i)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        dec.alu_op    = 2'b11;
        dec_dst       = bus.Rd_i;
        uses_rt       = 1'b1;
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec_dst       = bus.Rt_i;
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec_dst        = bus.Rt_i;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = 2'b01;
        uses_rt    = 1'b1;
      end
      OP_J:    ;
      default: legal = 1'b0;
    endcase
  end

  // Only instructions that read rt as a source can collide through Rt_i.
  always_comb begin
    hazard = 1'b0;
    if (HAZARD_EN)
      hazard = bus.Valid_i && idex_ctrl_q.mem_read && (idex_dst_q != '0) &&
               ((idex_dst_q == bus.Rs_i) || ((idex_dst_q == bus.Rt_i) && uses_rt));
  end

  always_comb begin
    idex_ctrl_d = dec;
    idex_dst_d  = dec_dst;
    if (!bus.Valid_i || !legal || hazard || bus.Flush_i) begin
      idex_ctrl_d = '0;
      idex_dst_d  = '0;
    end
    if (ZERO_REG_GUARD && (idex_dst_d == '0))
      idex_ctrl_d.reg_write = 1'b0;
  end

  // An illegal opcode held through a stall is counted on every cycle it is presented.
  always_comb begin
    ill_d = ill_q;
    cnt_d = cnt_q;
    if (bus.Valid_i && !legal && !bus.Flush_i) begin
      ill_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_ctrl_q  <= '0;
      idex_dst_q   <= '0;
      exmem_ctrl_q <= '0;
      exmem_dst_q  <= '0;
      memwb_ctrl_q <= '0;
      memwb_dst_q  <= '0;
      ill_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_dst_q   <= idex_dst_d;
      exmem_ctrl_q <= '{reg_write:  idex_ctrl_q.reg_write,
                        mem_to_reg: idex_ctrl_q.mem_to_reg,
                        branch:     idex_ctrl_q.branch,
                        mem_read:   idex_ctrl_q.mem_read,
                        mem_write:  idex_ctrl_q.mem_write};
      exmem_dst_q  <= idex_dst_q;
      memwb_ctrl_q <= '{reg_write:  exmem_ctrl_q.reg_write,
                        mem_to_reg: exmem_ctrl_q.mem_to_reg};
      memwb_dst_q  <= exmem_dst_q;
      ill_q        <= ill_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.Stall_o      = hazard && !bus.Flush_i;
  assign bus.Jump_o       = bus.Valid_i && (bus.Op_i == OP_J);
  assign bus.ExRegDst_o   = idex_ctrl_q.reg_dst;
  assign bus.ExALUOp_o    = idex_ctrl_q.alu_op;
  assign bus.ExALUSrc_o   = idex_ctrl_q.alu_src;
  assign bus.ExDst_o      = idex_dst_q;
  assign bus.MemRead_o    = exmem_ctrl_q.mem_read;
  assign bus.MemWrite_o   = exmem_ctrl_q.mem_write;
  assign bus.MemBranch_o  = exmem_ctrl_q.branch;
  assign bus.WbRegWrite_o = memwb_ctrl_q.reg_write;
  assign bus.WbMemtoReg_o = memwb_ctrl_q.mem_to_reg;
  assign bus.WbDst_o      = memwb_dst_q;
  assign bus.Illegal_o    = ill_q;
  assign bus.IllegalCnt_o = cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: decode table, multi-cycle hazard/flush/reset sequences, random run vs. stage model.
module tb_ctrl_pipe_unit;
  localparam int AW = 5;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  ctrl_pipe_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

  ctrl_pipe_unit #(
    .REG_ADDR_W(AW), .CNT_W(CW), .HAZARD_EN(1'b1), .ZERO_REG_GUARD(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: each stage holds the spec bundle {RegWrite,MemtoReg,Branch,MemRead,MemWrite,RegDst,ALUOp,ALUSrc} + dst.
  typedef struct packed {
    logic [8:0] b;
    logic [4:0] dst;
  } stage_t;

  stage_t pipe [3];
  int     ill_count;
  logic   ill_flag;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       jump;
    logic [8:0] ex;
    logic [2:0] mem;
    logic [6:0] wb;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [9:0] spec_row(input logic [5:0] op);
    case (op)
      6'h00:   return {1'b1, 9'b1_0_0_0_0_1_11_0};
      6'h08:   return {1'b1, 9'b1_0_0_0_0_0_00_1};
      6'h23:   return {1'b1, 9'b1_1_0_1_0_0_00_1};
      6'h2B:   return {1'b1, 9'b0_0_0_0_1_0_00_1};
      6'h04:   return {1'b1, 9'b0_0_1_0_0_0_01_0};
      6'h02:   return {1'b1, 9'b0};
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [31:0] dut_vec();
    return {2'b0, bus.Stall_o, bus.Jump_o, bus.ExRegDst_o, bus.ExALUOp_o, bus.ExALUSrc_o,
            bus.ExDst_o, bus.MemRead_o, bus.MemWrite_o, bus.MemBranch_o, bus.WbRegWrite_o,
            bus.WbMemtoReg_o, bus.WbDst_o, bus.Illegal_o, bus.IllegalCnt_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    ill_count = 0;
    ill_flag  = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                       input logic fl);
    bus.Valid_i = v;
    bus.Op_i    = op;
    bus.Rs_i    = rs;
    bus.Rt_i    = rt;
    bus.Rd_i    = rd;
    bus.Flush_i = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Compare all outputs with the model for the current cycle, then step the model across the edge.
  task automatic advance();
    logic [9:0]  row;
    logic        uses_rt, haz;
    logic [4:0]  d;
    stage_t      nxt;
    logic [31:0] exp;
    row     = spec_row(bus.Op_i);
    uses_rt = bus.Op_i inside {6'h00, 6'h2B, 6'h04};
    haz     = bus.Valid_i && pipe[0].b[5] && (pipe[0].dst != 5'd0) &&
              ((pipe[0].dst == bus.Rs_i) || ((pipe[0].dst == bus.Rt_i) && uses_rt));
    exp = {2'b0, haz && !bus.Flush_i, bus.Valid_i && (bus.Op_i == 6'h02),
           pipe[0].b[3], pipe[0].b[2:1], pipe[0].b[0], pipe[0].dst,
           pipe[1].b[5], pipe[1].b[4], pipe[1].b[6],
           pipe[2].b[8], pipe[2].b[7], pipe[2].dst, ill_flag, ill_count[7:0]};
    chk("model_cycle", dut_vec(), exp);
    d = (bus.Op_i == 6'h00) ? bus.Rd_i :
        (bus.Op_i inside {6'h08, 6'h23}) ? bus.Rt_i : 5'd0;
    if (!bus.Valid_i || !row[9] || haz || bus.Flush_i) nxt = '0;
    else begin
      nxt.b   = row[8:0];
      nxt.dst = d;
      if (d == 5'd0) nxt.b[8] = 1'b0;
    end
    if (bus.Valid_i && !row[9] && !bus.Flush_i) begin
      ill_flag = 1'b1;
      if (ill_count < 255) ill_count++;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nxt;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      idle();
      advance();
    end
  endtask

  initial begin
    logic [5:0] op;
    tbl[0] = '{6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 9'b1_11_0_00011, 3'b000, 7'b1_0_00011};
    tbl[1] = '{6'h08, 5'd1, 5'd7, 5'd3, 1'b0, 9'b0_00_1_00111, 3'b000, 7'b1_0_00111};
    tbl[2] = '{6'h08, 5'd1, 5'd0, 5'd3, 1'b0, 9'b0_00_1_00000, 3'b000, 7'b0_0_00000};
    tbl[3] = '{6'h23, 5'd1, 5'd5, 5'd3, 1'b0, 9'b0_00_1_00101, 3'b100, 7'b1_1_00101};
    tbl[4] = '{6'h2B, 5'd1, 5'd6, 5'd3, 1'b0, 9'b0_00_1_00000, 3'b010, 7'b0_0_00000};
    tbl[5] = '{6'h04, 5'd1, 5'd2, 5'd3, 1'b0, 9'b0_01_0_00000, 3'b001, 7'b0_0_00000};
    tbl[6] = '{6'h02, 5'd1, 5'd2, 5'd3, 1'b1, 9'b0_00_0_00000, 3'b000, 7'b0_0_00000};
    tbl[7] = '{6'h3F, 5'd1, 5'd2, 5'd3, 1'b0, 9'b0_00_0_00000, 3'b000, 7'b0_0_00000};
    tbl[8] = '{6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 9'b1_11_0_00000, 3'b000, 7'b0_0_00000};

    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", dut_vec(), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, 1'b0);
      chk($sformatf("tbl%0d_jump", i), {31'b0, bus.Jump_o}, {31'b0, tbl[i].jump});
      advance();
      idle();
      chk($sformatf("tbl%0d_ex", i),
          {23'b0, bus.ExRegDst_o, bus.ExALUOp_o, bus.ExALUSrc_o, bus.ExDst_o}, {23'b0, tbl[i].ex});
      advance();
      idle();
      chk($sformatf("tbl%0d_mem", i),
          {29'b0, bus.MemRead_o, bus.MemWrite_o, bus.MemBranch_o}, {29'b0, tbl[i].mem});
      advance();
      idle();
      chk($sformatf("tbl%0d_wb", i),
          {25'b0, bus.WbRegWrite_o, bus.WbMemtoReg_o, bus.WbDst_o}, {25'b0, tbl[i].wb});
      advance();
    end

    // lw r5 followed by a dependent add: one stall cycle, then the add proceeds.
    drive(1'b1, 6'h23, 5'd1, 5'd5, 5'd0, 1'b0);
    advance();
    drive(1'b1, 6'h00, 5'd5, 5'd1, 5'd9, 1'b0);
    chk("luse_stall", {31'b0, bus.Stall_o}, 32'd1);
    advance();
    drive(1'b1, 6'h00, 5'd5, 5'd1, 5'd9, 1'b0);
    chk("luse_stall_once", {31'b0, bus.Stall_o}, 32'd0);
    chk("luse_ex_bubble", {23'b0, bus.ExRegDst_o, bus.ExALUOp_o, bus.ExALUSrc_o, bus.ExDst_o}, 32'd0);
    advance();
    idle();
    chk("luse_add_ex", {24'b0, bus.ExRegDst_o, bus.ExALUOp_o, bus.ExDst_o}, {24'b0, 1'b1, 2'b11, 5'd9});
    advance();
    drain();

    // Same pair but the add is flushed: no stall, bubble in EX, lw still moves to MEM.
    drive(1'b1, 6'h23, 5'd1, 5'd5, 5'd0, 1'b0);
    advance();
    drive(1'b1, 6'h00, 5'd5, 5'd1, 5'd9, 1'b1);
    chk("flush_no_stall", {31'b0, bus.Stall_o}, 32'd0);
    advance();
    idle();
    chk("flush_ex_bubble", {23'b0, bus.ExRegDst_o, bus.ExALUOp_o, bus.ExALUSrc_o, bus.ExDst_o}, 32'd0);
    chk("flush_lw_mem", {31'b0, bus.MemRead_o}, 32'd1);
    advance();
    drain();

    // sw then beq.
    drive(1'b1, 6'h2B, 5'd1, 5'd2, 5'd0, 1'b0);
    advance();
    drive(1'b1, 6'h04, 5'd1, 5'd2, 5'd0, 1'b0);
    advance();
    idle();
    chk("sw_mem_write", {31'b0, bus.MemWrite_o}, 32'd1);
    advance();
    idle();
    chk("beq_mem_branch", {31'b0, bus.MemBranch_o}, 32'd1);
    chk("sw_no_wb", {31'b0, bus.WbRegWrite_o}, 32'd0);
    advance();
    idle();
    chk("beq_no_wb", {31'b0, bus.WbRegWrite_o}, 32'd0);
    advance();

    // Illegal opcode held for 300 cycles saturates the counter.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 6'h3F, 5'd1, 5'd2, 5'd3, 1'b0);
      advance();
    end
    idle();
    chk("ill_flag", {31'b0, bus.Illegal_o}, 32'd1);
    chk("ill_cnt_sat", {24'b0, bus.IllegalCnt_o}, 32'd255);
    chk("ill_bundles_zero", dut_vec() & 32'h3FFF_FE00, 32'd0);
    advance();

    // Asynchronous reset while a lw sits in MEM.
    drive(1'b1, 6'h23, 5'd1, 5'd5, 5'd0, 1'b0);
    advance();
    idle();
    advance();
    idle();
    chk("rst_pre_memread", {31'b0, bus.MemRead_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_memread", {31'b0, bus.MemRead_o}, 32'd0);
    chk("rst_async_all", dut_vec(), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("rst_release_ill", {23'b0, bus.Illegal_o, bus.IllegalCnt_o}, 32'd0);
    advance();

    // Random traffic with small register indices to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0:       op = 6'h00;
        1:       op = 6'h08;
        2, 3:    op = 6'h23;
        4:       op = 6'h2B;
        5:       op = 6'h04;
        6:       op = 6'h02;
        default: op = 6'($urandom_range(0, 63));
      endcase
      drive($urandom_range(0, 9) != 0, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Pipelined successor to the single-cycle main decoder.
- Decodes the ID-stage opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers alongside the destination register index.
- Detects load-use hazards and applies branch flushes.
- Flags and counts illegal opcodes in hardware; there is no simulation-only print.

Parameters:
REG_ADDR_W, 5, width of register indices Rs/Rt/Rd.
CNT_W, 8, width of the saturating illegal-opcode counter.
HAZARD_EN, 1, 1 = load-use stall logic active; 0 = Stall_o tied 0.
ZERO_REG_GUARD, 1, 1 = RegWrite suppressed when the destination index is 0.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset; asynchronous, active-low.
Valid_i  in  1  ID-stage instruction valid.
Op_i  in  6  ID-stage opcode.
Rs_i  in  REG_ADDR_W  ID-stage rs index.
Rt_i  in  REG_ADDR_W  ID-stage rt index.
Rd_i  in  REG_ADDR_W  ID-stage rd index.
Flush_i  in  1  branch taken, resolved in EX; kill younger instructions.
Stall_o  out  1  hold PC and IF/ID this cycle (combinational).
Jump_o  out  1  ID-stage jump decode (combinational).
ExRegDst_o  out  1  EX-stage RegDst.
ExALUOp_o  out  2  EX-stage ALUOp.
ExALUSrc_o  out  1  EX-stage ALUSrc.
ExDst_o  out  REG_ADDR_W  EX-stage destination index.
MemRead_o  out  1  MEM-stage MemRead.
MemWrite_o  out  1  MEM-stage MemWrite.
MemBranch_o  out  1  MEM-stage Branch.
WbRegWrite_o  out  1  WB-stage RegWrite.
WbMemtoReg_o  out  1  WB-stage MemtoReg.
WbDst_o  out  REG_ADDR_W  WB-stage destination index.
Illegal_o  out  1  sticky illegal-opcode flag.
IllegalCnt_o  out  CNT_W  illegal-opcode count, saturating.

Behaviour:

Decode (combinational, ID). Bundle fields are RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp, ALUSrc.
- R-type 000000: 1,0,0,0,0,1,11,0.
- addi 001000: 1,0,0,0,0,0,00,1.
- lw 100011: 1,1,0,1,0,0,00,1.
- sw 101011: 0,0,0,0,1,0,00,1.
- beq 000100: 0,0,1,0,0,0,01,0.
- j 000010: all zero; Jump_o=1.
- Any other opcode: all-zero bubble (illegal).
- Jump_o is only asserted when Valid_i=1.

Destination index:
- Rd_i for R-type; Rt_i for addi and lw; 0 otherwise.
- With ZERO_REG_GUARD=1, a destination of 0 forces RegWrite=0 in the bundle entering ID/EX.

Pipeline timing:
- ID/EX loads on each rising edge. EX fields appear 1 cycle after Op_i is sampled, MEM fields 2 cycles after, WB fields 3 cycles after.
- EX/MEM and MEM/WB always advance; they are never stalled.

Load-use hazard (HAZARD_EN=1):
- Condition: Valid_i AND ID/EX.MemRead AND ExDst_o!=0 AND (ExDst_o==Rs_i OR (ExDst_o==Rt_i AND the ID op is R-type, sw or beq)).
- Response: Stall_o=1 and ID/EX loads a bubble. The stall lasts exactly 1 cycle because the bubble clears the condition.

Flush_i=1:
- ID/EX loads a bubble and Stall_o is forced to 0; flush wins over stall.
- EX/MEM captures the current EX contents normally.

Bubble rule:
- Valid_i=0, an illegal opcode, stall or flush all load an all-zero bundle with destination 0.

Illegal opcode:
- Counted when Valid_i=1 and no flush is active, including during a stall.
- Sets Illegal_o, which stays set until reset.
- IllegalCnt_o increments by 1 and saturates at 2^CNT_W-1, with no wrap.
- Counting occurs once per cycle the illegal opcode is presented.

Reset:
- rst_i low clears all pipeline registers, Illegal_o and IllegalCnt_o to 0 immediately, regardless of clock.
- Therefore every registered output reads 0 during reset.
- If reset is asserted mid-stall or mid-flush, both are abandoned; deassertion resumes from an empty pipeline.

Test Plan:
- lw with Rt=5 at cycle 0, then add with Rs=5 at cycle 1 -> Stall_o=1 in cycle 1 only; the EX bundle is zero at cycle 2; the add reaches EX at cycle 3 with ExALUOp_o=11, ExRegDst_o=1.
- lw with Rt=5, then add with Rs=5, and Flush_i=1 in the same cycle as the add -> Stall_o=0; the EX bundle is zero the next cycle.
- addi with Rt=0 (ZERO_REG_GUARD=1) -> WbRegWrite_o=0 three cycles later; addi with Rt=7 -> WbRegWrite_o=1 and WbDst_o=7.
- Opcode 111111 presented 300 times with CNT_W=8 -> Illegal_o=1, IllegalCnt_o=255, and all bundles zero.
- sw, then beq -> MemWrite_o=1 at cycle 2 and MemBranch_o=1 at cycle 3; WbRegWrite_o stays 0.
- Reset pulled low mid-sequence while a lw is in MEM -> MemRead_o=0 immediately; Illegal_o=0 and IllegalCnt_o=0 after reset is released.
